// File: rtl/stopwatch_bcd_counter.sv
// Debounced push-button stopwatch producing a registered 4-digit packed-BCD count (SS.hh).
// Define LAP_HOLD_EN to enable the lap-hold display freeze on btn_lap.
module stopwatch_bcd_counter #(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] bcd_out,
  output logic        update,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

`ifdef LAP_HOLD_EN
  localparam int unsigned NBTN = 3;
`else
  localparam int unsigned NBTN = 2;
`endif

  localparam int unsigned BTN_SS  = 0;
  localparam int unsigned BTN_CLR = 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  logic [NBTN-1:0]         w_btn_raw;
  logic [NBTN-1:0]         r_sync1;
  logic [NBTN-1:0]         r_sync2;
  logic [NBTN-1:0]         r_db_level;
  logic [NBTN-1:0]         r_db_prev;
  logic [NBTN-1:0]         r_press;
  logic [NBTN-1:0][DW-1:0] r_db_cnt;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic [15:0]   r_count;
  logic [15:0]   w_count_next;
  logic [16:0]   w_inc;
  logic [15:0]   r_bcd;
  logic [15:0]   w_bcd_next;
  logic          r_update;
  logic          r_running;
  logic          r_overflow;
  logic          w_overflow_next;
  logic          w_hold_next;
  logic          w_tick;
  logic          w_clear;
  logic          w_press_ss;
  logic          w_press_clr;

`ifdef LAP_HOLD_EN
  localparam int unsigned BTN_LAP = 2;
  logic r_hold;
  logic w_press_lap;
  assign w_btn_raw   = {btn_lap, btn_clear, btn_start_stop};
  assign w_press_lap = r_press[BTN_LAP];
`else
  logic w_unused_lap;
  assign w_btn_raw    = {btn_clear, btn_start_stop};
  assign w_unused_lap = btn_lap;
`endif

  assign w_press_ss  = r_press[BTN_SS];
  assign w_press_clr = r_press[BTN_CLR];

  // Increment packed BCD by one; bit 16 is the carry out of the tens-of-seconds digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] s;
    logic        c;
    s = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[4*d +: 4] >= 4'd9) begin
          s[4*d +: 4] = 4'd0;
        end else begin
          s[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, s};
  endfunction

  // Synchronise, debounce and edge-detect every button; press pulses are registered.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_db_level <= '0;
      r_db_prev  <= '0;
      r_press    <= '0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      r_press   <= r_db_level & ~r_db_prev;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (r_sync2[i] != r_db_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_level[i] <= r_sync2[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_tick  = (r_state == StRun) && (r_presc == PRESC_LAST);
  // Clear is only legal outside RUN; when legal it overrides a simultaneous start/stop.
  assign w_clear = w_press_clr && (r_state != StRun);
  assign w_inc   = bcd_inc(r_count);

  always_comb begin
    w_state_next    = r_state;
    w_presc_next    = r_presc;
    w_count_next    = r_count;
    w_overflow_next = r_overflow;

    if (r_state == StRun) begin
      w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    end
    if (w_tick) begin
      w_count_next = w_inc[15:0];
      if (w_inc[16]) begin
        w_overflow_next = 1'b1;
      end
    end

    if (w_clear) begin
      w_state_next    = StIdle;
      w_presc_next    = '0;
      w_count_next    = '0;
      w_overflow_next = 1'b0;
    end else if (w_press_ss) begin
      case (r_state)
        StIdle: begin
          w_state_next = StRun;
          w_presc_next = '0;
        end
        StRun:   w_state_next = StPause;
        StPause: w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
`ifdef LAP_HOLD_EN
    w_hold_next = r_hold;
    if (w_clear) begin
      w_hold_next = 1'b0;
    end else if (w_press_lap && (r_state == StRun)) begin
      w_hold_next = ~r_hold;
    end
`else
    w_hold_next = 1'b0;
`endif
    // While held the display keeps its value; on release it reloads the live count.
    w_bcd_next = w_hold_next ? r_bcd : w_count_next;
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_presc    <= '0;
      r_count    <= '0;
      r_bcd      <= '0;
      r_update   <= 1'b0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_count    <= w_count_next;
      r_bcd      <= w_bcd_next;
      r_update   <= (w_bcd_next != r_bcd);
      r_running  <= (w_state_next == StRun);
      r_overflow <= w_overflow_next;
    end
  end

`ifdef LAP_HOLD_EN
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= w_hold_next;
    end
  end
`endif

  assign bcd_out  = r_bcd;
  assign update   = r_update;
  assign running  = r_running;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: DIV=10 main instance plus a DIV=2 instance
// used to reach the 99.99 -> 00.00 wrap in a short run.
module tb_stopwatch_bcd_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ss, clr, lap;
  logic [15:0] bcd;
  logic        upd, run, ovf;

  logic        b2_ss, b2_clr, b2_lap;
  logic [15:0] bcd2;
  logic        upd2, run2, ovf2;

  int total = 0;
  int bad   = 0;
  int ups;
  int n;
  int first;
  int found;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .btn_start_stop (ss),
    .btn_clear      (clr),
    .btn_lap        (lap),
    .bcd_out        (bcd),
    .update         (upd),
    .running        (run),
    .overflow       (ovf)
  );

  stopwatch_bcd_counter #(
    .CLK_HZ          (200),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut2 (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .btn_start_stop (b2_ss),
    .btn_clear      (b2_clr),
    .btn_lap        (b2_lap),
    .bcd_out        (bcd2),
    .update         (upd2),
    .running        (run2),
    .overflow       (ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ss = 1'b0; clr = 1'b0; lap = 1'b0;
    b2_ss = 1'b0; b2_clr = 1'b0; b2_lap = 1'b0;
    #1;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_upd", upd, 0);
    chk("rst_run", run, 0);
    chk("rst_ovf", ovf, 0);
    step(2);
    reset = 1'b0;
    step(3);

    // 3-cycle glitch must be rejected
    ss = 1'b1; step(3); ss = 1'b0;
    step(12);
    chk("glitch_run", run, 0);
    chk("glitch_bcd", bcd, 16'h0000);

    // clean press: 2 sync + 4 debounce + 1 edge + 1 state = 8 edges
    ss = 1'b1;
    step(7);
    chk("press_lat_early", run, 0);
    step(1);
    chk("press_lat", run, 1);
    ss = 1'b0;

    ups = 0; first = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1);
      if (upd) begin
        ups++;
        if (first == 0) first = i;
      end
      if (i == 9) chk("cnt_pre_first", bcd, 16'h0000);
      if (i == 100) chk("cnt_tenths_carry", bcd, 16'h0010);
    end
    chk("first_inc_cycle", first, 10);
    chk("cnt_100_ticks", bcd, 16'h0100);
    chk("ups_100_ticks", ups, 100);

    // clear while running is ignored
    clr = 1'b1; step(8); clr = 1'b0;
    step(12);
    chk("clr_in_run_bcd", bcd, 16'h0102);
    chk("clr_in_run_run", run, 1);

    // asynchronous reset at 12.34
    found = 0;
    for (int i = 0; i < 12000 && found == 0; i++) begin
      step(1);
      if (bcd == 16'h1234) found = 1;
    end
    chk("reach_1234", found, 1);
    chk("upd_at_1234", upd, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_bcd", bcd, 16'h0000);
    chk("async_rst_upd", upd, 0);
    chk("async_rst_run", run, 0);
    chk("async_rst_ovf", ovf, 0);
    step(2);
    reset = 1'b0;
    step(20);
    chk("post_rst_bcd", bcd, 16'h0000);
    chk("post_rst_run", run, 0);
    chk("post_rst_upd", upd, 0);

    // pause 5 cycles into a tick period, then resume
    ss = 1'b1; step(8); ss = 1'b0;
    chk("restart_run", run, 1);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(1);
      if (upd) n = i;
    end
    chk("restart_first", n, 10);
    step(7);
    ss = 1'b1; step(8); ss = 1'b0;
    chk("pause_run", run, 0);
    chk("pause_bcd", bcd, 16'h0002);
    step(50);
    chk("paused_bcd_held", bcd, 16'h0002);
    chk("paused_run", run, 0);
    ss = 1'b1; step(8); ss = 1'b0;
    chk("resume_run", run, 1);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(1);
      if (upd) n = i;
    end
    chk("resume_fraction", n, 5);
    chk("resume_bcd", bcd, 16'h0003);

    // pause then clear
    step(10);
    ss = 1'b1; step(8); ss = 1'b0;
    chk("pause2_run", run, 0);
    chk("pause2_bcd", bcd, 16'h0004);
    step(12);
    clr = 1'b1;
    step(7);
    chk("clr_pending_bcd", bcd, 16'h0004);
    step(1);
    chk("clr_bcd", bcd, 16'h0000);
    chk("clr_upd", upd, 1);
    chk("clr_run", run, 0);
    chk("clr_ovf", ovf, 0);
    step(1);
    chk("clr_upd_single", upd, 0);
    clr = 1'b0;
    step(12);

    // clear on an already-zero count produces no update
    clr = 1'b1;
    ups = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (upd) ups++;
    end
    clr = 1'b0;
    chk("clr_zero_noupd", ups, 0);
    step(12);

    // from IDLE the prescaler restarts at zero
    ss = 1'b1; step(8); ss = 1'b0;
    chk("idle_start_run", run, 1);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(1);
      if (upd) n = i;
    end
    chk("idle_presc_zero", n, 10);
    chk("idle_first_bcd", bcd, 16'h0001);

    // lap press at 00.20, run 30 ticks, lap again
    step(185);
    lap = 1'b1; step(8); lap = 1'b0;
    chk("lap_at_20", bcd, 16'h0020);
    ups = 0;
    for (int i = 0; i < 297; i++) begin
      step(1);
      if (upd) ups++;
    end
`ifdef LAP_HOLD_EN
    chk("lap_hold_bcd", bcd, 16'h0020);
    chk("lap_hold_noupd", ups, 0);
`else
    chk("lap_ignored_bcd", bcd, 16'h0050);
    chk("lap_ignored_ups", ups, 30);
`endif
    lap = 1'b1;
    step(7);
`ifdef LAP_HOLD_EN
    chk("lap_release_pending", bcd, 16'h0020);
`endif
    step(1);
    chk("lap_release_bcd", bcd, 16'h0050);
`ifdef LAP_HOLD_EN
    chk("lap_release_upd", upd, 1);
`endif
    lap = 1'b0;

    // DIV=2 instance: 10000 ticks wrap 99.99 -> 00.00
    b2_ss = 1'b1; step(8); b2_ss = 1'b0;
    chk("div2_run", run2, 1);
    n = 0;
    for (int i = 1; i <= 20100 && n == 0; i++) begin
      step(1);
      if (i == 19998) chk("div2_pre_wrap", bcd2, 16'h9999);
      if (ovf2) n = i;
    end
    chk("div2_wrap_cycle", n, 20000);
    chk("div2_wrap_bcd", bcd2, 16'h0000);
    chk("div2_wrap_upd", upd2, 1);
    step(2);
    chk("div2_after_wrap_bcd", bcd2, 16'h0001);
    chk("div2_ovf_sticky", ovf2, 1);
    chk("div2_still_run", run2, 1);
    chk("main_ovf_clear", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
